bsg_cache_dma_arb: RTL and testbench
====================================

# bsg_cache_dma_arb

Shares one memory-side DMA channel among `num_cache_p` cache DMA engines. It arbitrates their DMA packets with round-robin priority and holds each grant until the memory side accepts the packet. It then steers evict-data and fill-data bursts to and from the owning cache, using in-order ID FIFOs. It sits between the per-cache DMA ports and the memory controller or network adapter.

## Interface
Parameters:
- `num_cache_p`, none: number of caches sharing the channel; at least 2.
- `addr_width_p`, none: DMA address width.
- `data_width_p`, none: DMA data beat width.
- `block_size_in_words_p`, none: words per block; this is also the packet mask width.
- `burst_len_p`, none: data beats per block transfer; at least 1.
- `id_fifo_els_p`, 4: depth of each ID FIFO, read and write.
- `pkt_width_lp`, `1+addr_width_p+block_size_in_words_p`: packet width, laid out as {write_not_read, addr, mask}.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `dma_pkt_i` in `num_cache_p*pkt_width_lp`: per-cache packets.
- `dma_pkt_v_i` in `num_cache_p`: per-cache packet valid.
- `dma_pkt_yumi_o` out `num_cache_p`: per-cache packet accept.
- `dma_data_o` out `num_cache_p*data_width_p`: fill data to caches; the memory beat is broadcast to every cache.
- `dma_data_v_o` out `num_cache_p`: per-cache fill valid.
- `dma_data_ready_i` in `num_cache_p`: per-cache fill ready.
- `dma_data_i` in `num_cache_p*data_width_p`: evict data from caches.
- `dma_data_v_i` in `num_cache_p`: per-cache evict valid.
- `dma_data_yumi_o` out `num_cache_p`: per-cache evict accept.
- `mem_pkt_o` out `pkt_width_lp`: packet to memory.
- `mem_pkt_v_o` out 1: memory packet valid.
- `mem_pkt_yumi_i` in 1: memory packet accept.
- `mem_data_i` in `data_width_p`: fill beat from memory.
- `mem_data_v_i` in 1: fill beat valid.
- `mem_data_ready_o` out 1: fill beat ready.
- `mem_data_o` out `data_width_p`: evict beat to memory.
- `mem_data_v_o` out 1: evict beat valid.
- `mem_data_yumi_i` in 1: evict beat accept.

## Operation
Packet arbitration:
- Requester `i` is eligible when `dma_pkt_v_i[i]` is high and the ID FIFO for its packet type is not full. A read packet (`write_not_read`=0) needs space in the read-ID FIFO; a write packet needs space in the write-ID FIFO.
- Fullness is judged on registered occupancy only. A pop in the same cycle does not free a slot.
- Unlocked: the winner is the first eligible requester at or after `rr_ptr_r`, wrapping modulo `num_cache_p`. `mem_pkt_v_o` is high when any requester is eligible, and `mem_pkt_o` is the winner's packet.
- If `mem_pkt_v_o & ~mem_pkt_yumi_i`, the winner is latched: `lock_r`=1 and `lock_id_r`=winner. While locked, only `lock_id_r` is presented. Caches hold their packet stable while valid.
- On `mem_pkt_yumi_i`:
  - `dma_pkt_yumi_o[winner]`=1 and the lock is cleared.
  - `rr_ptr_r` becomes winner+1, wrapping.
  - The winner ID is pushed into the FIFO for its packet type.

Fill routing:
- `head_r` = read-FIFO head. `dma_data_v_o[head_r]` = `mem_data_v_i` & FIFO non-empty.
- `mem_data_ready_o` = FIFO non-empty & `dma_data_ready_i[head_r]`.
- Each accepted beat increments `fill_cnt_r`. On beat `burst_len_p`-1, the counter clears to 0 and the FIFO pops.

Evict routing:
- `head_w` = write-FIFO head. `mem_data_v_o` = FIFO non-empty & `dma_data_v_i[head_w]`, and `mem_data_o` = `dma_data_i[head_w]`.
- `dma_data_yumi_o[head_w]` = `mem_data_yumi_i`.
- `evict_cnt_r` counts beats and pops the FIFO on the last beat.
- Evict data from a non-head cache is never accepted.

Counters:
- Width is `clog2(burst_len_p)`, with a minimum of 1.
- With `burst_len_p`=1 every beat pops the FIFO.

Read and write paths are independent. A fill and an evict may complete in the same cycle, including for the same cache.

## Timing
- Reset values:
  - All `*_v_o` and `*_yumi_o` outputs are 0; `mem_data_ready_o` is 0.
  - `rr_ptr_r`=0, `lock_r`=0.
  - Both FIFOs are empty; both counters are 0.
- Reset mid-burst discards all outstanding IDs and partial counts.
- Packet path is combinational (0-cycle). A packet can be accepted in the cycle it is presented.
- An ID pushed at edge N is visible at the FIFO head after edge N. Data for that packet can therefore move from cycle N+1, one cycle after packet acceptance, at the earliest.
- Data paths are combinational pass-through, with no added latency and one beat per cycle.
- A memory fill beat arriving with the read FIFO empty is back-pressured (`mem_data_ready_o`=0). It is never dropped.

## Configuration
- `BSG_CACHE_DMA_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, with the lowest index eligible winning; `rr_ptr_r` is not built. Locking is unchanged.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset then idle: all valid/yumi outputs are 0 and `mem_data_ready_o`=0.
- `num_cache_p`=4, caches 0, 1 and 3 issue reads together, memory always accepts → grants in order 0, 1, 3, then 0 again if it is still requesting.
- Cache 2 write, `mem_pkt_yumi_i` held low 3 cycles while cache 0 raises a request → `mem_pkt_o` stays cache 2's packet until accepted; cache 0 is not granted meanwhile.
- `burst_len_p`=4, reads from caches 1 then 0 → fill beats 0–3 go to cache 1 and beats 4–7 to cache 0. `dma_data_ready_i[1]`=0 stalls `mem_data_ready_o`.
- Write FIFO full (4 IDs), a fifth write is pending, and an evict pop happens in the same cycle → no grant that cycle; the grant occurs the following cycle.
- `mem_data_v_i`=1 with no reads outstanding → `mem_data_ready_o`=0 and all `dma_data_v_o`=0.

Source files
------------

// File: rtl/bsg_cache_dma_arb.sv
// Shares one memory-side DMA channel among num_cache_p cache DMA engines.
// Define BSG_CACHE_DMA_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.

module bsg_cache_dma_arb_id_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [els_p-1:0][width_p-1:0] mem_r;
  logic [ptr_w-1:0]              rd_ptr_r, wr_ptr_r;
  logic [cnt_w-1:0]              cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_i) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r <= (wr_ptr_r == ptr_w'(els_p-1)) ? '0 : wr_ptr_r + ptr_w'(1);
      end
      if (pop_i)
        rd_ptr_r <= (rd_ptr_r == ptr_w'(els_p-1)) ? '0 : rd_ptr_r + ptr_w'(1);
      if (push_i & ~pop_i)
        cnt_r <= cnt_r + cnt_w'(1);
      else if (~push_i & pop_i)
        cnt_r <= cnt_r - cnt_w'(1);
    end
  end

  assign data_o  = mem_r[rd_ptr_r];
  assign empty_o = (cnt_r == '0);
  assign full_o  = (cnt_r == cnt_w'(els_p));
endmodule

module bsg_cache_dma_arb #(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int burst_len_p           = 1,
  parameter int id_fifo_els_p         = 4,
  parameter int pkt_width_lp          = 1 + addr_width_p + block_size_in_words_p
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_cache_p*pkt_width_lp-1:0]  dma_pkt_i,
  input  logic [num_cache_p-1:0]               dma_pkt_v_i,
  output logic [num_cache_p-1:0]               dma_pkt_yumi_o,
  output logic [num_cache_p*data_width_p-1:0]  dma_data_o,
  output logic [num_cache_p-1:0]               dma_data_v_o,
  input  logic [num_cache_p-1:0]               dma_data_ready_i,
  input  logic [num_cache_p*data_width_p-1:0]  dma_data_i,
  input  logic [num_cache_p-1:0]               dma_data_v_i,
  output logic [num_cache_p-1:0]               dma_data_yumi_o,
  output logic [pkt_width_lp-1:0]              mem_pkt_o,
  output logic                                 mem_pkt_v_o,
  input  logic                                 mem_pkt_yumi_i,
  input  logic [data_width_p-1:0]              mem_data_i,
  input  logic                                 mem_data_v_i,
  output logic                                 mem_data_ready_o,
  output logic [data_width_p-1:0]              mem_data_o,
  output logic                                 mem_data_v_o,
  input  logic                                 mem_data_yumi_i
);
  localparam int id_w  = $clog2(num_cache_p);
  localparam int cnt_w = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  typedef struct packed {
    logic                             write_not_read;
    logic [addr_width_p-1:0]          addr;
    logic [block_size_in_words_p-1:0] mask;
  } dma_pkt_s;

  dma_pkt_s [num_cache_p-1:0]                   pkts;
  logic     [num_cache_p-1:0][data_width_p-1:0] evict_data;
  assign pkts       = dma_pkt_i;
  assign evict_data = dma_data_i;

  logic                   rd_full, wr_full, rd_empty, wr_empty;
  logic                   rd_push, wr_push, rd_pop, wr_pop;
  logic [id_w-1:0]        head_r, head_w, win, lock_id_r;
  logic                   lock_r, arb_v, pkt_accept;
  logic [num_cache_p-1:0] elig;
  int                     idx;

  // Fullness comes from registered occupancy, so a same-cycle pop never frees a slot.
  for (genvar i = 0; i < num_cache_p; i++) begin : g_lane
    assign elig[i] = dma_pkt_v_i[i] & (pkts[i].write_not_read ? ~wr_full : ~rd_full);
  end

`ifndef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
  logic [id_w-1:0] rr_ptr_r;
`endif

  always_comb begin
    win   = '0;
    arb_v = |elig;
    idx   = 0;
`ifdef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
    for (int i = num_cache_p-1; i >= 0; i--)
      if (elig[i]) win = id_w'(i);
`else
    for (int k = num_cache_p-1; k >= 0; k--) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= num_cache_p) idx = idx - num_cache_p;
      if (elig[idx]) win = id_w'(idx);
    end
`endif
    if (lock_r) begin
      win   = lock_id_r;
      arb_v = elig[lock_id_r];
    end
  end

  assign mem_pkt_v_o = arb_v & ~reset_i;
  assign mem_pkt_o   = pkts[win];
  assign pkt_accept  = mem_pkt_v_o & mem_pkt_yumi_i;
  assign rd_push     = pkt_accept & ~pkts[win].write_not_read;
  assign wr_push     = pkt_accept &  pkts[win].write_not_read;

  always_comb begin
    dma_pkt_yumi_o = '0;
    if (pkt_accept) dma_pkt_yumi_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_r    <= 1'b0;
      lock_id_r <= '0;
    end else if (pkt_accept) begin
      lock_r    <= 1'b0;
    end else if (mem_pkt_v_o) begin
      lock_r    <= 1'b1;
      lock_id_r <= win;
    end
  end

`ifndef BSG_CACHE_DMA_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_ptr_r <= '0;
    else if (pkt_accept)
      rr_ptr_r <= (win == id_w'(num_cache_p-1)) ? '0 : win + id_w'(1);
  end
`endif

  bsg_cache_dma_arb_id_fifo #(.els_p(id_fifo_els_p), .width_p(id_w)) rd_fifo (
    .clk_i, .reset_i, .push_i(rd_push), .data_i(win), .pop_i(rd_pop),
    .data_o(head_r), .empty_o(rd_empty), .full_o(rd_full)
  );

  bsg_cache_dma_arb_id_fifo #(.els_p(id_fifo_els_p), .width_p(id_w)) wr_fifo (
    .clk_i, .reset_i, .push_i(wr_push), .data_i(win), .pop_i(wr_pop),
    .data_o(head_w), .empty_o(wr_empty), .full_o(wr_full)
  );

  // Fill path: memory beat is broadcast, only the read-FIFO head sees valid.
  logic [cnt_w-1:0] fill_cnt_r, evict_cnt_r;
  logic             fill_beat, fill_last, evict_beat, evict_last;

  assign dma_data_o       = {num_cache_p{mem_data_i}};
  assign mem_data_ready_o = ~rd_empty & dma_data_ready_i[head_r];
  assign fill_beat        = mem_data_v_i & mem_data_ready_o;
  assign fill_last        = (fill_cnt_r == cnt_w'(burst_len_p-1));
  assign rd_pop           = fill_beat & fill_last;

  always_comb begin
    dma_data_v_o         = '0;
    dma_data_v_o[head_r] = mem_data_v_i & ~rd_empty;
  end

  assign mem_data_v_o = ~wr_empty & dma_data_v_i[head_w];
  assign mem_data_o   = evict_data[head_w];
  assign evict_beat   = mem_data_v_o & mem_data_yumi_i;
  assign evict_last   = (evict_cnt_r == cnt_w'(burst_len_p-1));
  assign wr_pop       = evict_beat & evict_last;

  always_comb begin
    dma_data_yumi_o         = '0;
    dma_data_yumi_o[head_w] = evict_beat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fill_cnt_r  <= '0;
      evict_cnt_r <= '0;
    end else begin
      if (fill_beat)  fill_cnt_r  <= fill_last  ? '0 : fill_cnt_r  + cnt_w'(1);
      if (evict_beat) evict_cnt_r <= evict_last ? '0 : evict_cnt_r + cnt_w'(1);
    end
  end
endmodule

// File: tb/tb_bsg_cache_dma_arb.sv
// Bench for bsg_cache_dma_arb: packet-arbitration vector table, fill/evict scoreboard, lock and full-FIFO sequences.
module tb_bsg_cache_dma_arb;
  localparam int N = 4, AW = 8, DW = 16, BW = 4, BL = 4, PW = 1 + AW + BW;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*PW-1:0]   dma_pkt_i;
  logic [N-1:0]      dma_pkt_v_i, dma_pkt_yumi_o;
  logic [N*DW-1:0]   dma_data_o, dma_data_i;
  logic [N-1:0]      dma_data_v_o, dma_data_ready_i, dma_data_v_i, dma_data_yumi_o;
  logic [PW-1:0]     mem_pkt_o;
  logic              mem_pkt_v_o, mem_pkt_yumi_i;
  logic [DW-1:0]     mem_data_i, mem_data_o;
  logic              mem_data_v_i, mem_data_ready_o, mem_data_v_o, mem_data_yumi_i;

  logic [N-1:0][PW-1:0] pk;
  logic [N-1:0][DW-1:0] ev;
  assign dma_pkt_i  = pk;
  assign dma_data_i = ev;

  bsg_cache_dma_arb #(
    .num_cache_p(N), .addr_width_p(AW), .data_width_p(DW),
    .block_size_in_words_p(BW), .burst_len_p(BL), .id_fifo_els_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_pkt_o(mem_pkt_o), .mem_pkt_v_o(mem_pkt_v_o), .mem_pkt_yumi_i(mem_pkt_yumi_i),
    .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i), .mem_data_ready_o(mem_data_ready_o),
    .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o), .mem_data_yumi_i(mem_data_yumi_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int rd_q[$], wr_q[$];

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] w;
    logic         myumi;
    logic         exp_v;
    logic [N-1:0] exp_yumi;
    int           exp_win;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [PW-1:0] mk(input int i, input logic w);
    logic [AW-1:0] a;
    logic [BW-1:0] m;
    a = AW'(8'hA0 + i);
    m = BW'(i + 1);
    return {w, a, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkts(input logic [N-1:0] v, input logic [N-1:0] w);
    for (int i = 0; i < N; i++) pk[i] = mk(i, w[i]);
    dma_pkt_v_i = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_pkts('0, '0);
    mem_pkt_yumi_i = 1'b0; mem_data_i = '0; mem_data_v_i = 1'b0; mem_data_yumi_i = 1'b0;
    dma_data_ready_i = '0; dma_data_v_i = '0;
    for (int i = 0; i < N; i++) ev[i] = DW'(16'hE000 + i);
    tick(); tick();
    reset = 1'b0;
    rd_q.delete(); wr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_dv, rdy;
    int beats, cyc;

    // rr_ptr starts at 0; read FIFO fills after four grants; cache 2 write then locks.
    tbl[0] = '{4'b1011, 4'b0000, 1'b1, 1'b1, 4'b0001, 0};
    tbl[1] = '{4'b1011, 4'b0000, 1'b1, 1'b1, 4'b0010, 1};
    tbl[2] = '{4'b1011, 4'b0000, 1'b1, 1'b1, 4'b1000, 3};
    tbl[3] = '{4'b1011, 4'b0000, 1'b1, 1'b1, 4'b0001, 0};
    tbl[4] = '{4'b1011, 4'b0000, 1'b1, 1'b0, 4'b0000, 0};
    tbl[5] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0000, 2};
    tbl[6] = '{4'b0101, 4'b0100, 1'b1, 1'b1, 4'b0100, 2};

    do_reset();
    mem_data_v_i = 1'b1;
    #2;
    chk("rst_pkt_v", 64'(mem_pkt_v_o), 64'(0));
    chk("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(0));
    chk("rst_data_v_o", 64'(dma_data_v_o), 64'(0));
    chk("rst_data_yumi", 64'(dma_data_yumi_o), 64'(0));
    chk("rst_mem_data_v", 64'(mem_data_v_o), 64'(0));
    chk("rst_mem_ready", 64'(mem_data_ready_o), 64'(0));
    mem_data_v_i = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) begin
      set_pkts(tbl[r].v, tbl[r].w);
      mem_pkt_yumi_i = tbl[r].myumi;
      #2;
      chk($sformatf("vec%0d_v", r), 64'(mem_pkt_v_o), 64'(tbl[r].exp_v));
      chk($sformatf("vec%0d_yumi", r), 64'(dma_pkt_yumi_o), 64'(tbl[r].exp_yumi));
      if (tbl[r].exp_v)
        chk($sformatf("vec%0d_pkt", r), 64'(mem_pkt_o), 64'(mk(tbl[r].exp_win, tbl[r].w[tbl[r].exp_win])));
      if (tbl[r].exp_yumi != '0) begin
        if (tbl[r].w[tbl[r].exp_win]) wr_q.push_back(tbl[r].exp_win);
        else rd_q.push_back(tbl[r].exp_win);
      end
      tick();
    end
    set_pkts('0, '0);
    mem_pkt_yumi_i = 1'b0;

    // Fill scoreboard: bursts of BL beats per outstanding read ID, random valid/ready.
    beats = 0; cyc = 0;
    while (rd_q.size() > 0 && cyc < 300) begin
      mem_data_v_i = ($urandom_range(0, 3) != 0);
      mem_data_i   = DW'($urandom);
      rdy = '1;
      if (cyc == 2 || $urandom_range(0, 3) == 0) rdy[rd_q[0]] = 1'b0;
      dma_data_ready_i = rdy;
      #2;
      exp_dv = mem_data_v_i ? (N'(1) << rd_q[0]) : '0;
      chk("fill_v_o", 64'(dma_data_v_o), 64'(exp_dv));
      chk("fill_ready", 64'(mem_data_ready_o), 64'(rdy[rd_q[0]]));
      chk("fill_bcast", 64'(dma_data_o), 64'({N{mem_data_i}}));
      if (mem_data_v_i && rdy[rd_q[0]]) begin
        beats++;
        if (beats == BL) begin
          beats = 0;
          void'(rd_q.pop_front());
        end
      end
      tick();
      cyc++;
    end
    chk("fill_timeout", 64'(rd_q.size()), 64'(0));
    mem_data_v_i = 1'b1; dma_data_ready_i = '1;
    #2;
    chk("no_rd_ready", 64'(mem_data_ready_o), 64'(0));
    chk("no_rd_v_o", 64'(dma_data_v_o), 64'(0));
    mem_data_v_i = 1'b0;
    tick();

    // Evict of the cache 2 write; cache 3 offers data too but is never head.
    dma_data_v_i = 4'b1100;
    mem_data_yumi_i = 1'b1;
    for (int b = 0; b < BL; b++) begin
      #2;
      chk("ev_v", 64'(mem_data_v_o), 64'(1));
      chk("ev_data", 64'(mem_data_o), 64'(ev[wr_q[0]]));
      chk("ev_yumi", 64'(dma_data_yumi_o), 64'(N'(1) << wr_q[0]));
      tick();
    end
    void'(wr_q.pop_front());
    #2;
    chk("ev_done_v", 64'(mem_data_v_o), 64'(0));
    chk("ev_done_yumi", 64'(dma_data_yumi_o), 64'(0));
    dma_data_v_i = '0; mem_data_yumi_i = 1'b0;

    // Lock: cache 2 write stalled three cycles while cache 0 raises a read.
    do_reset();
    set_pkts(4'b0100, 4'b0100);
    #2;
    chk("lock_c0_pkt", 64'(mem_pkt_o), 64'(mk(2, 1'b1)));
    chk("lock_c0_yumi", 64'(dma_pkt_yumi_o), 64'(0));
    tick();
    for (int c = 1; c < 3; c++) begin
      set_pkts(4'b0101, 4'b0100);
      #2;
      chk($sformatf("lock_c%0d_v", c), 64'(mem_pkt_v_o), 64'(1));
      chk($sformatf("lock_c%0d_pkt", c), 64'(mem_pkt_o), 64'(mk(2, 1'b1)));
      chk($sformatf("lock_c%0d_yumi", c), 64'(dma_pkt_yumi_o), 64'(0));
      tick();
    end
    mem_pkt_yumi_i = 1'b1;
    #2;
    chk("lock_accept_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0100));
    chk("lock_accept_pkt", 64'(mem_pkt_o), 64'(mk(2, 1'b1)));
    tick();
    set_pkts(4'b0001, 4'b0000);
    #2;
    chk("after_lock_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0001));
    chk("after_lock_pkt", 64'(mem_pkt_o), 64'(mk(0, 1'b0)));
    tick();

    // Write FIFO full: fifth write waits until the cycle after the evict pop.
    do_reset();
    mem_pkt_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_pkts(4'b0010, 4'b0010);
      #2;
      chk($sformatf("wfill%0d_yumi", k), 64'(dma_pkt_yumi_o), 64'(4'b0010));
      tick();
    end
    set_pkts(4'b0100, 4'b0100);
    dma_data_v_i = 4'b1010;
    #2;
    chk("wfull_blocked", 64'(mem_pkt_v_o), 64'(0));
    tick();
    mem_data_yumi_i = 1'b1;
    for (int b = 0; b < BL; b++) begin
      #2;
      chk($sformatf("wfull_b%0d_pkt_v", b), 64'(mem_pkt_v_o), 64'(0));
      chk($sformatf("wfull_b%0d_ev_v", b), 64'(mem_data_v_o), 64'(1));
      chk($sformatf("wfull_b%0d_ev_data", b), 64'(mem_data_o), 64'(ev[1]));
      chk($sformatf("wfull_b%0d_ev_yumi", b), 64'(dma_data_yumi_o), 64'(4'b0010));
      tick();
    end
    mem_data_yumi_i = 1'b0; dma_data_v_i = '0;
    #2;
    chk("wfull_grant_v", 64'(mem_pkt_v_o), 64'(1));
    chk("wfull_grant_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0100));
    chk("wfull_grant_pkt", 64'(mem_pkt_o), 64'(mk(2, 1'b1)));
    tick();
    set_pkts('0, '0);
    mem_pkt_yumi_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
